pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the openMIPS core. Generalises the
//  fixed-field stage latches (if/id, id/ex, ex/mem, mem/wb) into one block.
//  Fields: a bubble-able payload, a sticky side-band that survives bubbles, and a valid bit.
//  Adds a synchronous flush for exceptions/eret and a saturating bubble counter.
//  Instantiated once per stage boundary; driven by the ctrl stall vector.
// PARAMETERS
//  DATA_W    64        payload width (aluop/alusel/operands/wd/wreg packed by the instantiator)
//  KEEP_W    2         sticky side-band width (e.g. delay-slot flags); held across bubbles
//  STAGE     2         index k of the upstream stage in stall[]; 0 <= k <= 4
//  NOP_DATA  {DATA_W{1'b0}}  payload value injected on reset, flush and bubble
//  CNT_W     16        bubble counter width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-high (`RstEnable)
//  stall      in   6        ctrl stall vector; stall[k]=`Stop freezes stage k
//  flush      in   1        synchronous flush; kills the payload in this register
//  in_data    in   DATA_W   payload from stage k
//  in_keep    in   KEEP_W   side-band from stage k
//  in_valid   in   1        stage k holds a real instruction
//  cnt_clr    in   1        synchronous clear of bubble_cnt
//  out_data   out  DATA_W   registered payload to stage k+1
//  out_keep   out  KEEP_W   registered side-band
//  out_valid  out  1        registered valid
//  bubble_cnt out  CNT_W    number of bubbles inserted, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): out_data=NOP_DATA, out_keep=0, out_valid=0, bubble_cnt=0.
//    Outputs take these values immediately, not at the next edge.
//  - Per rising edge, priority is flush > bubble > advance > hold:
//    flush=1                        : out_data=NOP_DATA, out_keep=0, out_valid=0.
//                                     Applies regardless of stall.
//    stall[k]=Stop & stall[k+1]=NoStop : bubble. out_data=NOP_DATA, out_valid=0,
//                                     out_keep HOLDS its previous value.
//    stall[k]=NoStop                : advance. out_data<=in_data, out_keep<=in_keep,
//                                     out_valid<=in_valid.
//    otherwise (k and k+1 stopped)  : hold all outputs.
//  - Latency is 1 cycle in advance mode. There is no combinational path from input to output.
//  - bubble_cnt:
//    * +1 on each bubble edge (not on flush or hold); saturates at all-ones, no wrap.
//    * cnt_clr=1 forces 0 on that edge and wins over a simultaneous increment.
//  - Illegal case: stall[k]=NoStop & stall[k+1]=Stop (ctrl never generates it).
//    The block treats it as advance; an assertion flags it in simulation.
//  - Reset asserted mid-stall or mid-flush: reset wins. After release the block
//    resumes per priority on the first edge.
// STRUCTURE
//  - `Stop/`NoStop, `RstEnable, `ZeroWord and NOP encodings come from define.v.
//    No new global macros.
//  - Sub-module pipe_sat_cnt #(W): saturating up-counter with sync clear and async reset.
//    It is reused by other stages' performance counters.
//  - STAGE range check is done with a generate-time $error.
// TESTING
//  1 rst=1 with in_data=64'hFFFF_FFFF, stall=0 -> out_data=0, out_valid=0, bubble_cnt=0
//    before any edge.
//  2 STAGE=2, stall=6'b000000, in_data=64'h1234, in_keep=2'b01, in_valid=1
//    -> next edge: out_data=64'h1234, out_keep=01, out_valid=1.
//  3 From state 2, stall=6'b000111 for 3 cycles -> out_data=0, out_keep stays 01,
//    out_valid=0, bubble_cnt=3.
//  4 stall=6'b001111 with out_data=64'h55 -> all outputs unchanged, bubble_cnt unchanged.
//    Then flush=1 with stall still 001111 -> out_data=0, out_keep=0, out_valid=0.
//  5 CNT_W=2, 5 consecutive bubbles -> bubble_cnt=3 (saturated).
//    cnt_clr=1 together with a bubble -> bubble_cnt=0.
//  6 rst pulsed asynchronously between edges during advance -> outputs reset immediately.
//    After release the next advance edge captures in_data.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared definitions for the inter-stage pipeline register.
//   - STOP / NO_STOP : encoding of one bit of the ctrl stall vector
//   - stage_act_e    : what the register does on a given clock edge
//   - decodeAction   : priority decode flush > bubble > advance > hold
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    STG_HOLD    = 2'd0,
    STG_ADVANCE = 2'd1,
    STG_BUBBLE  = 2'd2,
    STG_FLUSH   = 2'd3
  } stage_act_e;

  // Priority decode of the per-edge action. A running upstream stage always
  // advances, even when downstream is stopped; that combination never comes
  // from ctrl and is flagged separately by an assertion in the register.
  function automatic stage_act_e decodeAction(input logic flush,
                                              input logic stopUp,
                                              input logic stopDown);
    stage_act_e act;
    if (flush)
      act = STG_FLUSH;
    else if (stopUp == NO_STOP)
      act = STG_ADVANCE;
    else if (stopDown == NO_STOP)
      act = STG_BUBBLE;
    else
      act = STG_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_cnt.sv
// ---------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating up-counter with synchronous clear and asynchronous reset.
// Reused by the performance counters of other stages.
// Ports:
//   clk_i  : rising-edge clock
//   rst_i  : asynchronous reset, active-high
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : count one event on this edge
//   cnt_o  : current count, sticks at all-ones
// ---------------------------------------------------------------------------
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment only while not yet saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage pipeline register (if/id, id/ex, ex/mem, mem/wb).
// Holds a bubble-able payload, a sticky side-band that survives bubbles and
// a valid bit, plus a saturating count of inserted bubbles.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active-high
//   stall      : ctrl stall vector, stall[STAGE] / stall[STAGE+1] used here
//   flush      : synchronous kill of the held instruction
//   in_data    : payload from upstream stage
//   in_keep    : side-band from upstream stage
//   in_valid   : upstream stage holds a real instruction
//   cnt_clr    : synchronous clear of bubble_cnt
//   out_data   : registered payload to downstream stage
//   out_keep   : registered side-band
//   out_valid  : registered valid
//   bubble_cnt : saturating number of bubbles inserted
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                KEEP_W   = 2,
  parameter int                STAGE    = 2,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_valid,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // STAGE selects stall[STAGE] and stall[STAGE+1]; both must exist
  if ((STAGE < 0) || (STAGE > 4)) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must be in 0..4");
  end

  localparam int STAGE_DN = STAGE + 1;

  stage_act_e        act;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              valid_q, valid_d;

  // Decide what this edge does from flush and the two relevant stall bits
  always_comb begin
    act = decodeAction(flush, stall[STAGE], stall[STAGE_DN]);
  end

  // Next-state payload; a bubble kills data and valid but the side-band
  // keeps describing the instruction that is still waiting upstream
  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    unique case (act)
      STG_FLUSH: begin
        data_d  = NOP_DATA;
        keep_d  = '0;
        valid_d = 1'b0;
      end
      STG_BUBBLE: begin
        data_d  = NOP_DATA;
        valid_d = 1'b0;
      end
      STG_ADVANCE: begin
        data_d  = in_data;
        keep_d  = in_keep;
        valid_d = in_valid;
      end
      default: ;
    endcase
  end

  // Stage register with asynchronous reset to a NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= NOP_DATA;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  // Only true bubble edges are counted, not flushes or holds
  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .inc_i (act == STG_BUBBLE),
    .cnt_o (bubble_cnt)
  );

  // ctrl never runs a stage while stopping the one below it
  illegal_stall_a : assert property (@(posedge clk) disable iff (rst)
    !((stall[STAGE] == NO_STOP) && (stall[STAGE_DN] == STOP)));

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg at STAGE=2. A second instance with a
// 2-bit counter shares every input so that saturation is visible quickly.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [63:0] inData;
  logic [1:0]  inKeep;
  logic        inValid;
  logic        cntClr;

  logic [63:0] outData,  outData2;
  logic [1:0]  outKeep,  outKeep2;
  logic        outValid, outValid2;
  logic [15:0] bubbleCnt;
  logic [1:0]  bubbleCnt2;

  int cmpCount = 0;
  int errCount = 0;

  pipe_stage_reg #(
    .DATA_W(64), .KEEP_W(2), .STAGE(2), .CNT_W(16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_data    (inData),
    .in_keep    (inKeep),
    .in_valid   (inValid),
    .cnt_clr    (cntClr),
    .out_data   (outData),
    .out_keep   (outKeep),
    .out_valid  (outValid),
    .bubble_cnt (bubbleCnt)
  );

  pipe_stage_reg #(
    .DATA_W(64), .KEEP_W(2), .STAGE(2), .CNT_W(2)
  ) u_dut_small (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_data    (inData),
    .in_keep    (inKeep),
    .in_valid   (inValid),
    .cnt_clr    (cntClr),
    .out_data   (outData2),
    .out_keep   (outKeep2),
    .out_valid  (outValid2),
    .bubble_cnt (bubbleCnt2)
  );

  // Free-running 10-unit clock; inputs change and outputs are sampled on
  // the falling edge, well away from the active edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [5:0]  stallV,
                               input logic [63:0] dataV,
                               input logic [1:0]  keepV,
                               input logic        validV,
                               input logic        flushV,
                               input logic        clrV);
    stall   = stallV;
    inData  = dataV;
    inKeep  = keepV;
    inValid = validV;
    flush   = flushV;
    cntClr  = clrV;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [63:0] observed,
                             input logic [63:0] expected);
    cmpCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held with garbage on the inputs, before any clock edge
    rst = 1'b1;
    applyStimulus(6'b000000, 64'hFFFF_FFFF, 2'b11, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rst_data",  outData,   64'h0);
    checkOutput("rst_keep",  outKeep,   64'h0);
    checkOutput("rst_valid", outValid,  64'h0);
    checkOutput("rst_cnt",   bubbleCnt, 64'h0);

    // Advance: result appears only after the next edge
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(6'b000000, 64'h1234, 2'b01, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("adv_no_comb_path", outData, 64'h0);
    @(negedge clk);
    checkOutput("adv_data",  outData,  64'h1234);
    checkOutput("adv_keep",  outKeep,  64'h1);
    checkOutput("adv_valid", outValid, 64'h1);

    // Bubbles: payload becomes NOP, side-band sticks, counter runs
    applyStimulus(6'b000111, 64'hABCD, 2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bub1_cnt",  bubbleCnt, 64'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bub3_data",  outData,    64'h0);
    checkOutput("bub3_keep",  outKeep,    64'h1);
    checkOutput("bub3_valid", outValid,   64'h0);
    checkOutput("bub3_cnt",   bubbleCnt,  64'd3);
    checkOutput("bub3_cnt2",  bubbleCnt2, 64'd3);

    // Load 0x55 then hold with both stages stopped
    applyStimulus(6'b000000, 64'h55, 2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("load55_data", outData, 64'h55);
    applyStimulus(6'b001111, 64'h99, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("hold_data",  outData,   64'h55);
    checkOutput("hold_keep",  outKeep,   64'h2);
    checkOutput("hold_valid", outValid,  64'h1);
    checkOutput("hold_cnt",   bubbleCnt, 64'd3);

    // Flush overrides the hold
    applyStimulus(6'b001111, 64'h99, 2'b11, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_data",  outData,   64'h0);
    checkOutput("flush_keep",  outKeep,   64'h0);
    checkOutput("flush_valid", outValid,  64'h0);

    // Flush during a bubble pattern is not counted as a bubble
    applyStimulus(6'b000000, 64'h66, 2'b01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(6'b000111, 64'h66, 2'b01, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flushbub_keep", outKeep,   64'h0);
    checkOutput("flushbub_cnt",  bubbleCnt, 64'd3);

    // Clear while advancing, then five bubbles saturate the 2-bit counter
    applyStimulus(6'b000000, 64'h42, 2'b10, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("clr_cnt",  bubbleCnt,  64'd0);
    checkOutput("clr_cnt2", bubbleCnt2, 64'd0);
    checkOutput("clr_data", outData,    64'h42);
    applyStimulus(6'b000111, 64'h42, 2'b01, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("sat_cnt2", bubbleCnt2, 64'd3);
    checkOutput("sat_cnt",  bubbleCnt,  64'd5);
    checkOutput("sat_keep", outKeep,    64'h2);

    // Clear wins over a simultaneous bubble
    applyStimulus(6'b000111, 64'h42, 2'b01, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("clrbub_cnt",  bubbleCnt,  64'd0);
    checkOutput("clrbub_cnt2", bubbleCnt2, 64'd0);

    // One bubble, then advance 0x77, then an asynchronous reset mid-cycle
    applyStimulus(6'b000111, 64'h42, 2'b01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(6'b000000, 64'h77, 2'b01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_data", outData,   64'h77);
    checkOutput("pre_rst_cnt",  bubbleCnt, 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_data",  outData,   64'h0);
    checkOutput("arst_keep",  outKeep,   64'h0);
    checkOutput("arst_valid", outValid,  64'h0);
    checkOutput("arst_cnt",   bubbleCnt, 64'd0);
    #1 rst = 1'b0;
    inData = 64'h88;
    @(negedge clk);
    checkOutput("post_rst_data",  outData,  64'h88);
    checkOutput("post_rst_keep",  outKeep,  64'h1);
    checkOutput("post_rst_valid", outValid, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
